rggen_response_collector: RTL and testbench

//  Collects per-register responses (hit, ready, status, read data) for one host access and returns
//  a single registered response to the bus adapter. Sits downstream of the per-register blocks and

---
 rtl/rggen_response_collector_pkg.sv | 16 +
 rtl/rggen_or_reducer.sv | 17 +
 rtl/rggen_response_collector.sv | 140 ++++++++++++++
 tb/tb_rggen_response_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_response_collector_pkg.sv
// Shared constants for the register response path: bus status codes and counter sizing.
package rggen_response_collector_pkg;

  localparam logic [1:0] STATUS_OKAY         = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  // Width needed to count 0..timeout, never narrower than one bit.
  function automatic int unsigned counter_width(input int unsigned timeout);
    int unsigned w;
    w = (timeout == 0) ? 1 : $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// Bitwise OR of N packed WIDTH-bit slices.
module rggen_or_reducer #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned N     = 1
) (
  input  logic [WIDTH*N-1:0] i_data,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_result = o_result | i_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rggen_response_collector.sv
// Merges per-register responses for one host access into a single registered bus response,
// generating DECODE_ERROR on a miss and SLAVE_ERROR on timeout.
module rggen_response_collector
  import rggen_response_collector_pkg::*;
#(
  parameter int unsigned REGISTERS      = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_request_valid,
  output logic                            o_register_access,
  input  logic [REGISTERS-1:0]            i_register_active,
  input  logic [REGISTERS-1:0]            i_register_ready,
  input  logic [2*REGISTERS-1:0]          i_register_status,
  input  logic [DATA_WIDTH*REGISTERS-1:0] i_register_read_data,
  output logic                            o_response_valid,
  input  logic                            i_response_ready,
  output logic [1:0]                      o_response_status,
  output logic [DATA_WIDTH-1:0]           o_response_data
);

  localparam int unsigned CW = counter_width(TIMEOUT_CYCLES);
  localparam int unsigned RW = 2 + DATA_WIDTH;
  localparam logic [CW-1:0] TIMEOUT_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  state_e                state;
  state_e                state_next;
  logic [CW-1:0]         counter;
  logic [CW-1:0]         counter_next;
  logic [1:0]            status_next;
  logic [DATA_WIDTH-1:0] data_next;

  logic [REGISTERS-1:0]    hit_ready;
  logic [RW*REGISTERS-1:0] masked_response;
  logic                    any_active;
  logic                    any_hit;
  logic [RW-1:0]           merged_response;
  logic                    timeout_hit;

  assign hit_ready = i_register_active & i_register_ready;

  // Slots that are not ready contribute nothing to the merged response.
  always_comb begin
    masked_response = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (i_register_ready[i]) begin
        masked_response[i*RW +: RW] =
          {i_register_status[2*i +: 2], i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  rggen_or_reducer #(.WIDTH(1), .N(REGISTERS)) u_active_reducer (
    .i_data   (i_register_active),
    .o_result (any_active)
  );

  rggen_or_reducer #(.WIDTH(1), .N(REGISTERS)) u_ready_reducer (
    .i_data   (hit_ready),
    .o_result (any_hit)
  );

  rggen_or_reducer #(.WIDTH(RW), .N(REGISTERS)) u_response_reducer (
    .i_data   (masked_response),
    .o_result (merged_response)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (counter == TIMEOUT_LAST);

  always_comb begin
    state_next   = state;
    counter_next = counter;
    status_next  = o_response_status;
    data_next    = o_response_data;
    case (state)
      IDLE: begin
        counter_next = '0;
        if (i_request_valid) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!i_request_valid) begin
          state_next = IDLE;
        end else if (!any_active) begin
          status_next = STATUS_DECODE_ERROR;
          data_next   = '0;
          state_next  = RESPOND;
        end else if (any_hit) begin
          status_next = merged_response[RW-1 -: 2];
          data_next   = merged_response[DATA_WIDTH-1:0];
          state_next  = RESPOND;
        end else if (timeout_hit) begin
          status_next = STATUS_SLAVE_ERROR;
          data_next   = '0;
          state_next  = RESPOND;
        end else if (counter != '1) begin
          counter_next = counter + CW'(1);
        end
      end
      RESPOND: begin
        if (i_response_ready) begin
          state_next   = IDLE;
          counter_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      counter           <= '0;
      o_register_access <= 1'b0;
      o_response_valid  <= 1'b0;
      o_response_status <= STATUS_OKAY;
      o_response_data   <= '0;
    end else begin
      state             <= state_next;
      counter           <= counter_next;
      o_register_access <= (state_next == ACCESS);
      o_response_valid  <= (state_next == RESPOND);
      o_response_status <= status_next;
      o_response_data   <= data_next;
    end
  end

endmodule

// File: tb/tb_rggen_response_collector.sv
// Randomized and directed checks of the response collector against a transaction-level model.
module tb_rggen_response_collector;

  localparam int unsigned REGS    = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            request_valid;
  logic [REGS-1:0] reg_active;
  logic [REGS-1:0] reg_ready;
  logic [2*REGS-1:0]  reg_status;
  logic [DW*REGS-1:0] reg_data;
  logic            response_ready;

  logic            access0, valid0, access1, valid1;
  logic [1:0]      status0, status1;
  logic [DW-1:0]   data0, data1;

  int checks = 0;
  int errors = 0;

  int          tx_rc[REGS];
  logic [1:0]  tx_st[REGS];
  logic [31:0] tx_dt[REGS];

  always #5 clk = ~clk;

  rggen_response_collector #(
    .REGISTERS(REGS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_request_valid      (request_valid),
    .o_register_access    (access0),
    .i_register_active    (reg_active),
    .i_register_ready     (reg_ready),
    .i_register_status    (reg_status),
    .i_register_read_data (reg_data),
    .o_response_valid     (valid0),
    .i_response_ready     (response_ready),
    .o_response_status    (status0),
    .o_response_data      (data0)
  );

  rggen_response_collector #(
    .REGISTERS(REGS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)
  ) dut_no_timeout (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_request_valid      (request_valid),
    .o_register_access    (access1),
    .i_register_active    (reg_active),
    .i_register_ready     (reg_ready),
    .i_register_status    (reg_status),
    .i_register_read_data (reg_data),
    .o_response_valid     (valid1),
    .i_response_ready     (response_ready),
    .o_response_status    (status1),
    .o_response_data      (data1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One complete access: the model predicts ACCESS length and the response from the slot table.
  task automatic run_txn(input logic [REGS-1:0] act, input int hold);
    int          first;
    int          n_access;
    logic [1:0]  exp_st;
    logic [31:0] exp_dt;
    first = -1;
    for (int i = 0; i < REGS; i++)
      if (act[i] && tx_rc[i] >= 0 && (first < 0 || tx_rc[i] < first)) first = tx_rc[i];
    exp_st = 2'b00;
    exp_dt = '0;
    if (act == '0) begin
      n_access = 1;
      exp_st   = 2'b11;
    end else if (first >= 0 && first < int'(TIMEOUT)) begin
      n_access = first + 1;
      for (int i = 0; i < REGS; i++)
        if (tx_rc[i] == first) begin
          exp_st = exp_st | tx_st[i];
          exp_dt = exp_dt | tx_dt[i];
        end
    end else begin
      n_access = int'(TIMEOUT);
      exp_st   = 2'b10;
    end

    @(negedge clk);
    request_valid  = 1'b1;
    reg_active     = act;
    reg_ready      = '0;
    response_ready = 1'b0;
    for (int i = 0; i < REGS; i++) begin
      reg_status[2*i +: 2] = tx_st[i];
      reg_data[DW*i +: DW] = tx_dt[i];
    end
    for (int idx = 0; idx < n_access; idx++) begin
      @(negedge clk);
      check_eq("access_high", 64'(access0), 64'd1);
      check_eq("valid_low_in_access", 64'(valid0), 64'd0);
      for (int i = 0; i < REGS; i++) reg_ready[i] = (tx_rc[i] == idx);
    end
    @(negedge clk);
    reg_ready = '0;
    check_eq("resp_valid", 64'(valid0), 64'd1);
    check_eq("resp_access_low", 64'(access0), 64'd0);
    check_eq("resp_status", 64'(status0), 64'(exp_st));
    check_eq("resp_data", 64'(data0), 64'(exp_dt));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(valid0), 64'd1);
      check_eq("hold_status", 64'(status0), 64'(exp_st));
      check_eq("hold_data", 64'(data0), 64'(exp_dt));
    end
    response_ready = 1'b1;
    request_valid  = 1'b0;
    @(negedge clk);
    response_ready = 1'b0;
    check_eq("idle_valid", 64'(valid0), 64'd0);
    check_eq("idle_access", 64'(access0), 64'd0);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < REGS; i++) begin
      tx_rc[i] = -1;
      tx_st[i] = 2'b00;
      tx_dt[i] = '0;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    request_valid  = 1'b1;
    reg_active     = '0;
    reg_ready      = '0;
    reg_status     = '0;
    reg_data       = '0;
    response_ready = 1'b0;

    // Reset held with a pending request.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_access", 64'(access0), 64'd0);
      check_eq("rst_valid", 64'(valid0), 64'd0);
      check_eq("rst_status", 64'(status0), 64'd0);
      check_eq("rst_data", 64'(data0), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_access", 64'(access0), 64'd1);
    request_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_abort", 64'(access0), 64'd0);

    // Normal read from slot 2, held for three cycles.
    clear_slots();
    tx_rc[2] = 0;
    tx_dt[2] = 32'hA5A5_0001;
    run_txn(4'b0100, 3);

    // Decode error.
    clear_slots();
    tx_dt[0] = 32'h1234_5678;
    run_txn(4'b0000, 1);

    // Masking of an active but not-ready slot.
    clear_slots();
    tx_rc[1] = 0;
    tx_dt[1] = 32'h0000_00F0;
    tx_dt[3] = 32'hFFFF_FFFF;
    tx_st[3] = 2'b11;
    run_txn(4'b1010, 0);

    // Abort in ACCESS.
    @(negedge clk);
    request_valid = 1'b1;
    reg_active    = 4'b0001;
    reg_ready     = '0;
    @(negedge clk);
    check_eq("abort_access0", 64'(access0), 64'd1);
    @(negedge clk);
    check_eq("abort_access1", 64'(access0), 64'd1);
    request_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_idle_access", 64'(access0), 64'd0);
    check_eq("abort_no_valid", 64'(valid0), 64'd0);
    @(negedge clk);
    check_eq("abort_still_no_valid", 64'(valid0), 64'd0);

    // Reset while RESPOND is waiting.
    request_valid = 1'b1;
    reg_active    = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(valid0), 64'd1);
    check_eq("pre_rst_status", 64'(status0), 64'd3);
    rst_n          = 1'b0;
    response_ready = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(valid0), 64'd0);
    check_eq("mid_rst_status", 64'(status0), 64'd0);
    request_valid = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    check_eq("after_rst_valid", 64'(valid0), 64'd0);
    check_eq("after_rst_access", 64'(access0), 64'd0);

    // Timeout on both instances: slot 0 active, never ready.
    request_valid = 1'b1;
    reg_active    = 4'b0001;
    reg_ready     = '0;
    reg_data      = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_eq("to_access", 64'(access0), 64'(c < int'(TIMEOUT)));
      check_eq("to_valid", 64'(valid0), 64'(c >= int'(TIMEOUT)));
      if (c >= int'(TIMEOUT)) begin
        check_eq("to_status", 64'(status0), 64'd2);
        check_eq("to_data", 64'(data0), 64'd0);
      end
      check_eq("nto_access", 64'(access1), 64'd1);
      check_eq("nto_valid", 64'(valid1), 64'd0);
    end
    request_valid  = 1'b0;
    response_ready = 1'b1;
    @(negedge clk);
    response_ready = 1'b0;
    check_eq("to_done_valid", 64'(valid0), 64'd0);
    check_eq("nto_abort_access", 64'(access1), 64'd0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [REGS-1:0] act;
      int r;
      act = REGS'($urandom_range(0, 15));
      for (int i = 0; i < REGS; i++) begin
        r        = int'($urandom_range(0, 7));
        tx_rc[i] = (act[i] && r != 7) ? r : -1;
        tx_st[i] = 2'($urandom);
        tx_dt[i] = $urandom;
      end
      run_txn(act, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
